// File: rtl/octave_transpose_ctrl.sv
// Keyboard octave/transpose controller: HID command keys with auto-repeat
// step an octave index and a semitone offset into a clamped base note.
module octave_transpose_ctrl #(
    parameter int          NUM_OCT       = 7,
    parameter int          NOTES_PER_OCT = 12,
    parameter int          NOTE_LOW      = 6,
    parameter int          RESET_OCT     = 0,
    parameter int          WRAP          = 0,
    parameter logic [7:0]  KEY_OCT_DN    = 8'h2C,
    parameter logic [7:0]  KEY_OCT_UP    = 8'h2D,
    parameter logic [7:0]  KEY_SEMI_DN   = 8'h2F,
    parameter logic [7:0]  KEY_SEMI_UP   = 8'h30,
    parameter logic [7:0]  KEY_CLR       = 8'h2A,
    parameter int          REPEAT_DLY    = 25_000_000,
    parameter int          REPEAT_PER    = 5_000_000
) (
    input  logic                       Clk,
    input  logic                       Reset_n,
    input  logic [7:0]                 keycode,
    output logic [$clog2(NUM_OCT)-1:0] octave_idx,
    output logic [NUM_OCT-1:0]         octave_onehot,
    output logic signed [4:0]          transpose,
    output logic [7:0]                 note_base,
    output logic                       changed
);

    localparam int               OW       = $clog2(NUM_OCT);
    localparam logic [OW-1:0]    OCT_MAX  = OW'(NUM_OCT - 1);
    localparam logic [OW-1:0]    OCT_RST  = OW'(RESET_OCT);
    localparam logic signed [4:0] T_MAX   = 5'(NOTES_PER_OCT - 1);
    localparam logic signed [4:0] T_MIN   = -T_MAX;
    localparam logic [7:0]       NOTE_RST =
        8'(NOTE_LOW + RESET_OCT * NOTES_PER_OCT);

    logic [7:0]         r_prev_key;
    logic [31:0]        r_cnt;
    logic               r_rep_ph;
    logic [OW-1:0]      r_oct;
    logic signed [4:0]  r_trans;
    logic [7:0]         r_note;
    logic               r_chg;

    logic               w_is_cmd;
    logic               w_same;
    logic               w_press;
    logic               w_hold;
    logic               w_rep;
    logic               w_ev;
    logic [9:0]         w_pos;
    logic signed [9:0]  w_sum;
    logic [7:0]         w_clamp;
    logic [NUM_OCT-1:0] w_onehot;

    assign w_is_cmd = (keycode == KEY_OCT_DN)  || (keycode == KEY_OCT_UP) ||
                      (keycode == KEY_SEMI_DN) || (keycode == KEY_SEMI_UP) ||
                      (keycode == KEY_CLR);
    assign w_same   = (keycode == r_prev_key);
    assign w_press  = w_is_cmd && !w_same;
    assign w_hold   = w_is_cmd && w_same && (REPEAT_DLY > 0);
    // First repeat after REPEAT_DLY held cycles, then every REPEAT_PER.
    assign w_rep    = w_hold && (r_rep_ph ? (r_cnt == 32'(REPEAT_PER))
                                          : (r_cnt == 32'(REPEAT_DLY)));
    assign w_ev     = w_press || w_rep;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_prev_key <= 8'h00;
            r_cnt      <= '0;
            r_rep_ph   <= 1'b0;
        end else begin
            r_prev_key <= keycode;
            if (w_rep) begin
                r_cnt    <= 32'd1;
                r_rep_ph <= 1'b1;
            end else if (w_press) begin
                r_cnt    <= 32'd1;
                r_rep_ph <= 1'b0;
            end else if (w_hold) begin
                r_cnt    <= r_cnt + 32'd1;
            end else begin
                r_cnt    <= '0;
                r_rep_ph <= 1'b0;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_oct   <= OCT_RST;
            r_trans <= '0;
        end else if (w_ev) begin
            unique case (1'b1)
                (keycode == KEY_OCT_UP): begin
                    if (r_oct == OCT_MAX)
                        r_oct <= (WRAP != 0) ? '0 : r_oct;
                    else
                        r_oct <= r_oct + 1'b1;
                end
                (keycode == KEY_OCT_DN): begin
                    if (r_oct == '0)
                        r_oct <= (WRAP != 0) ? OCT_MAX : r_oct;
                    else
                        r_oct <= r_oct - 1'b1;
                end
                (keycode == KEY_SEMI_UP): begin
                    if (r_trans != T_MAX)
                        r_trans <= r_trans + 5'sd1;
                end
                (keycode == KEY_SEMI_DN): begin
                    if (r_trans != T_MIN)
                        r_trans <= r_trans - 5'sd1;
                end
                (keycode == KEY_CLR): r_trans <= '0;
                default: ;
            endcase
        end
    end

    // Unsigned partial sum plus sign-extended offset gives the signed total.
    assign w_pos = 10'(NOTE_LOW) + 10'(r_oct) * 10'(NOTES_PER_OCT);
    assign w_sum = $signed(w_pos + {{5{r_trans[4]}}, r_trans});

    always_comb begin
        w_clamp = w_sum[7:0];
        if (w_sum < 10'sd0)
            w_clamp = 8'd0;
        else if (w_sum > 10'sd127)
            w_clamp = 8'd127;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_note <= NOTE_RST;
            r_chg  <= 1'b0;
        end else begin
            r_note <= w_clamp;
            r_chg  <= (w_clamp != r_note);
        end
    end

    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < NUM_OCT; i++)
            w_onehot[i] = (int'(r_oct) == NUM_OCT - 1 - i);
    end

    assign octave_idx    = r_oct;
    assign octave_onehot = w_onehot;
    assign transpose     = r_trans;
    assign note_base     = r_note;
    assign changed       = r_chg;

endmodule

// File: tb/tb_octave_transpose_ctrl.sv
// Bench for octave_transpose_ctrl: default instance driven from a vector
// table with a note scoreboard, plus a wrap/fast-repeat instance.
module tb_octave_transpose_ctrl;

    localparam logic [7:0] K_ODN = 8'h2C;
    localparam logic [7:0] K_OUP = 8'h2D;
    localparam logic [7:0] K_SDN = 8'h2F;
    localparam logic [7:0] K_SUP = 8'h30;
    localparam logic [7:0] K_CLR = 8'h2A;

    logic              clk = 1'b0;
    logic              rst0, rst1;
    logic [7:0]        kc0, kc1;
    logic [2:0]        oct0, oct1;
    logic [6:0]        oh0, oh1;
    logic signed [4:0] tr0, tr1;
    logic [7:0]        nb0, nb1;
    logic              chg0, chg1;

    int n_chk  = 0;
    int n_fail = 0;
    int row_pulses = 0;
    logic [7:0] sb[$];

    typedef struct {
        logic [7:0] kc;
        int         cyc;
        int         oct;
        int         trans;
        int         note;
        int         pulses;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    octave_transpose_ctrl u_dut0 (
        .Clk(clk), .Reset_n(rst0), .keycode(kc0),
        .octave_idx(oct0), .octave_onehot(oh0), .transpose(tr0),
        .note_base(nb0), .changed(chg0)
    );

    octave_transpose_ctrl #(
        .WRAP(1), .REPEAT_DLY(4), .REPEAT_PER(2)
    ) u_dut1 (
        .Clk(clk), .Reset_n(rst1), .keycode(kc1),
        .octave_idx(oct1), .octave_onehot(oh1), .transpose(tr1),
        .note_base(nb1), .changed(chg1)
    );

    task automatic chk(input string nm, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input logic [7:0] kc, input int cyc,
                                input int oct, input int trans,
                                input int note, input int pulses);
        vec_t v;
        v.kc = kc; v.cyc = cyc; v.oct = oct;
        v.trans = trans; v.note = note; v.pulses = pulses;
        vecs.push_back(v);
    endfunction

    // Scoreboard: every strobe on the default instance must match a queued note.
    always @(posedge clk) begin
        #1;
        if (rst0 && chg0) begin
            row_pulses++;
            n_chk++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_strobe: note_base=%0d, expected no strobe",
                         nb0);
            end else begin
                logic [7:0] e_note;
                e_note = sb.pop_front();
                if (nb0 !== e_note) begin
                    n_fail++;
                    $display("FAIL sb_note: got %0d, expected %0d",
                             nb0, e_note);
                end
            end
        end
    end

    initial begin
        int exp_tr[10];
        int p1;

        rst0 = 1'b0; rst1 = 1'b0; kc0 = 8'h00; kc1 = 8'h00;

        add(K_OUP, 10, 1, 0, 18, 1);
        add(K_OUP, 1, 2, 0, 30, 1);
        add(K_OUP, 1, 3, 0, 42, 1);
        add(K_OUP, 1, 4, 0, 54, 1);
        add(K_OUP, 1, 5, 0, 66, 1);
        add(K_OUP, 1, 6, 0, 78, 1);
        add(K_OUP, 1, 6, 0, 78, 0);
        add(K_OUP, 1, 6, 0, 78, 0);
        add(K_ODN, 1, 5, 0, 66, 1);
        add(8'h04, 2, 5, 0, 66, 0);
        add(K_SUP, 3, 5, 1, 67, 1);
        add(K_SUP, 1, 5, 2, 68, 1);
        add(K_CLR, 1, 5, 0, 66, 1);
        add(K_CLR, 1, 5, 0, 66, 0);
        for (int i = 0; i < 5; i++)
            add(K_ODN, 1, 4 - i, 0, 54 - 12 * i, 1);
        for (int i = 1; i <= 12; i++) begin
            int t;
            t = (i > 11) ? -11 : -i;
            add(K_SDN, 1, 0, t, (6 + t < 0) ? 0 : 6 + t, (i <= 6) ? 1 : 0);
        end
        add(K_CLR, 1, 0, 0, 6, 1);
        for (int i = 1; i <= 12; i++) begin
            int t;
            t = (i > 11) ? 11 : i;
            add(K_SUP, 1, 0, t, 6 + t, (i <= 11) ? 1 : 0);
        end

        tick(); tick();
        chk("rst_oct", int'(oct0), 0);
        chk("rst_trans", int'(tr0), 0);
        chk("rst_note", int'(nb0), 6);
        chk("rst_changed", int'(chg0), 0);
        chk("rst_onehot", int'(oh0), 'h40);
        rst0 = 1'b1; rst1 = 1'b1;
        tick();

        foreach (vecs[r]) begin
            row_pulses = 0;
            if (vecs[r].pulses != 0)
                sb.push_back(8'(vecs[r].note));
            kc0 = vecs[r].kc;
            for (int c = 0; c < vecs[r].cyc; c++) tick();
            kc0 = 8'h00;
            tick(); tick(); tick();
            chk($sformatf("row%0d_oct", r), int'(oct0), vecs[r].oct);
            chk($sformatf("row%0d_trans", r), int'(tr0), vecs[r].trans);
            chk($sformatf("row%0d_note", r), int'(nb0), vecs[r].note);
            chk($sformatf("row%0d_pulses", r), row_pulses, vecs[r].pulses);
            chk($sformatf("row%0d_sb_drain", r), sb.size(), 0);
            sb.delete();
            if (r == 0)
                chk("onehot_oct1", int'(oh0), 'h20);
            if (r == 7)
                chk("onehot_oct6", int'(oh0), 'h01);
        end

        kc1 = K_ODN;
        tick();
        chk("wrap_dn_oct", int'(oct1), 6);
        kc1 = 8'h00;
        tick(); tick();
        chk("wrap_dn_note", int'(nb1), 78);

        exp_tr = '{1, 1, 1, 1, 2, 2, 3, 3, 4, 4};
        p1 = 0;
        kc1 = K_SUP;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (chg1) p1++;
            chk($sformatf("rep_trans_c%0d", k), int'(tr1), exp_tr[k]);
        end
        kc1 = 8'h00;
        tick();
        if (chg1) p1++;
        tick();
        chk("rep_pulses", p1, 4);
        chk("rep_note", int'(nb1), 82);

        kc1 = K_OUP;
        tick();
        kc1 = 8'h00;
        tick(); tick();
        chk("wrap_up_oct", int'(oct1), 0);
        chk("wrap_up_note", int'(nb1), 10);

        kc1 = K_SUP;
        tick(); tick(); tick();
        #2 rst1 = 1'b0;
        #1;
        chk("arst_oct", int'(oct1), 0);
        chk("arst_trans", int'(tr1), 0);
        chk("arst_note", int'(nb1), 6);
        chk("arst_changed", int'(chg1), 0);
        #1 rst1 = 1'b1;
        tick();
        chk("arst_repress", int'(tr1), 1);
        tick();
        chk("arst_repress_note", int'(nb1), 7);
        kc1 = 8'h00;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
